// File: rtl/simple_exec_unit.sv
// Execution datapath for the 16-bit SIMPLE processor.
// Contains a combinational ALU with flags, a holdable cycle counter and a synchronous data memory.
module simple_exec_unit #(
    parameter int DM_ADDR_WIDTH = 12,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [3:0]           alu_op,
    input  logic [15:0]          alu_a,
    input  logic [15:0]          alu_b,
    output logic [15:0]          alu_out,
    output logic [3:0]           flag_out,
    output logic                 flag_write,
    input  logic                 cnt_hold,
    output logic [CNT_WIDTH-1:0] cnt_out,
    input  logic [15:0]          dm_address,
    input  logic [15:0]          dm_data,
    input  logic                 dm_wren,
    output logic [15:0]          dm_q
);

    localparam int DM_DEPTH = 2 ** DM_ADDR_WIDTH;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_CMP  = 4'd5,
        OP_MOV  = 4'd6,
        OP_MUL  = 4'd7,
        OP_SLL  = 4'd8,
        OP_SLR  = 4'd9,
        OP_SRL  = 4'd10,
        OP_SRA  = 4'd11,
        OP_IN   = 4'd12,
        OP_OUT  = 4'd13,
        OP_NONE = 4'd14,
        OP_HALT = 4'd15
    } alu_op_e;

    logic [16:0] sum_w;
    logic [16:0] diff_w;
    logic [15:0] prod_w;
    logic [3:0]  shamt;
    logic [31:0] sll_w;
    logic [31:0] rot_w;
    logic [31:0] srl_w;
    logic [31:0] sra_w;

    assign sum_w  = {1'b0, alu_a} + {1'b0, alu_b};
    assign diff_w = {1'b0, alu_a} - {1'b0, alu_b};
    assign prod_w = alu_a * alu_b;
    assign shamt  = alu_b[3:0];

    // Shifts run in a 32-bit window so the bit shifted out lands at a fixed position (0 when shamt is 0).
    assign sll_w = {16'h0000, alu_a} << shamt;
    assign rot_w = {alu_a, alu_a} << shamt;
    assign srl_w = {alu_a, 16'h0000} >> shamt;
    assign sra_w = $signed({alu_a, 16'h0000}) >>> shamt;

    logic [15:0] res;
    logic        carry;
    logic        ovf;
    logic        fwrite;

    always_comb begin
        res    = 16'h0000;
        carry  = 1'b0;
        ovf    = 1'b0;
        fwrite = 1'b1;
        case (alu_op_e'(alu_op))
            OP_ADD: begin
                res   = sum_w[15:0];
                carry = sum_w[16];
                ovf   = (alu_a[15] == alu_b[15]) && (sum_w[15] != alu_a[15]);
            end
            OP_SUB, OP_CMP: begin
                res   = diff_w[15:0];
                carry = diff_w[16];
                ovf   = (alu_a[15] != alu_b[15]) && (diff_w[15] != alu_a[15]);
            end
            OP_AND: res = alu_a & alu_b;
            OP_OR:  res = alu_a | alu_b;
            OP_XOR: res = alu_a ^ alu_b;
            OP_MOV: res = alu_b;
            OP_MUL: res = prod_w;
            OP_SLL: begin
                res   = sll_w[15:0];
                carry = sll_w[16];
            end
            OP_SLR: begin
                res   = rot_w[31:16];
                carry = (shamt != 4'd0) && rot_w[16];
            end
            OP_SRL: begin
                res   = srl_w[31:16];
                carry = srl_w[15];
            end
            OP_SRA: begin
                res   = sra_w[31:16];
                carry = sra_w[15];
            end
            OP_IN: begin
                res    = alu_b;
                fwrite = 1'b0;
            end
            OP_OUT: begin
                res    = alu_a;
                fwrite = 1'b0;
            end
            default: begin
                res    = 16'h0000;
                fwrite = 1'b0;
            end
        endcase
    end

    assign alu_out    = res;
    assign flag_out   = {res[15], (res == 16'h0000), carry, ovf};
    assign flag_write = fwrite;

    logic [15:0]              mem [DM_DEPTH];
    logic [DM_ADDR_WIDTH-1:0] dm_index;
    logic                     unused_addr_bits;

    // Upper address bits are deliberately dropped so addresses alias modulo the depth.
    assign dm_index         = dm_address[DM_ADDR_WIDTH-1:0];
    assign unused_addr_bits = ^dm_address[15:DM_ADDR_WIDTH];

    always_ff @(posedge clock) begin
        if (dm_wren && !reset) begin
            mem[dm_index] <= dm_data;
        end
    end

    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
    logic [15:0]          rdata_d, rdata_q;

    always_comb begin
        cnt_d   = cnt_hold ? cnt_q : cnt_q + CNT_WIDTH'(1);
        rdata_d = mem[dm_index];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            rdata_q <= 16'h0000;
        end else begin
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign cnt_out = cnt_q;
    assign dm_q    = rdata_q;

endmodule

// File: tb/tb_simple_exec_unit.sv
// Self-checking bench for simple_exec_unit: directed and randomized ALU, counter and memory checks
// against a behavioural model; a second narrow instance exercises counter wrap.
module tb_simple_exec_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  alu_op;
    logic [15:0] alu_a, alu_b;
    wire  [15:0] alu_out;
    wire  [3:0]  flag_out;
    wire         flag_write;
    logic        cnt_hold;
    wire  [31:0] cnt_out;
    logic [15:0] dm_address, dm_data;
    logic        dm_wren;
    wire  [15:0] dm_q;

    logic        s_cnt_hold;
    wire  [15:0] s_alu_out;
    wire  [3:0]  s_flag_out;
    wire         s_flag_write;
    wire  [3:0]  s_cnt_out;
    wire  [15:0] s_dm_q;

    int     total = 0;
    int     bad   = 0;
    longint exp_cnt;
    int     exp_cnt_s;

    logic [15:0] mem_model [4096];
    bit          mem_valid [4096];

    simple_exec_unit dut (
        .clock(clock), .reset(reset),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .flag_out(flag_out), .flag_write(flag_write),
        .cnt_hold(cnt_hold), .cnt_out(cnt_out),
        .dm_address(dm_address), .dm_data(dm_data), .dm_wren(dm_wren), .dm_q(dm_q)
    );

    simple_exec_unit #(.DM_ADDR_WIDTH(4), .CNT_WIDTH(4)) dut_small (
        .clock(clock), .reset(reset),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(s_alu_out), .flag_out(s_flag_out), .flag_write(s_flag_write),
        .cnt_hold(s_cnt_hold), .cnt_out(s_cnt_out),
        .dm_address(dm_address), .dm_data(dm_data), .dm_wren(dm_wren), .dm_q(s_dm_q)
    );

    always #5 clock = ~clock;

    // Reference ALU: signed/unsigned integer arithmetic and bit-at-a-time shifting.
    function automatic void alu_model(input int op, input int a, input int b,
                                      output int r, output int f, output int fw);
        int sa, sb, s, n, c, v;
        c  = 0;
        v  = 0;
        r  = 0;
        fw = (op <= 11) ? 1 : 0;
        n  = b & 15;
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        case (op)
            0: begin
                r = (a + b) & 65535;
                c = (a + b > 65535) ? 1 : 0;
                s = sa + sb;
                v = (s > 32767 || s < -32768) ? 1 : 0;
            end
            1, 5: begin
                r = (a - b) & 65535;
                c = (a < b) ? 1 : 0;
                s = sa - sb;
                v = (s > 32767 || s < -32768) ? 1 : 0;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            6: r = b;
            7: r = int'((longint'(a) * longint'(b)) % 65536);
            8: begin
                r = a;
                for (int i = 0; i < n; i++) begin
                    c = (r >> 15) & 1;
                    r = (r << 1) & 65535;
                end
            end
            9: begin
                r = a;
                for (int i = 0; i < n; i++) r = ((r << 1) | ((r >> 15) & 1)) & 65535;
                if (n > 0) c = r & 1;
            end
            10: begin
                r = a;
                for (int i = 0; i < n; i++) begin
                    c = r & 1;
                    r = r >> 1;
                end
            end
            11: begin
                r = a;
                for (int i = 0; i < n; i++) begin
                    c = r & 1;
                    r = (r >> 1) | (r & 32768);
                end
            end
            12: r = b;
            13: r = a;
            default: r = 0;
        endcase
        f = ((r >> 15) & 1) * 8 + ((r == 0) ? 4 : 0) + c * 2 + v;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        alu_op = op;
        alu_a  = a;
        alu_b  = b;
        #1;
    endtask

    task automatic aluDirected(input string tag, input logic [3:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] r, input logic [3:0] f,
                               input logic fw);
        applyStimulus(op, a, b);
        checkOutput({tag, "_out"}, alu_out, r);
        checkOutput({tag, "_flags"}, flag_out, f);
        checkOutput({tag, "_fw"}, flag_write, fw);
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) begin
            exp_cnt   = 0;
            exp_cnt_s = 0;
        end else begin
            if (!cnt_hold) exp_cnt = (exp_cnt + 1) & 64'hFFFF_FFFF;
            if (!s_cnt_hold) exp_cnt_s = (exp_cnt_s + 1) % 16;
        end
        #1;
    endtask

    // One memory cycle: reads return the pre-write contents of the addressed word.
    task automatic memStep(input logic [15:0] addr, input logic [15:0] data, input logic wren);
        int          idx;
        logic [15:0] expq;
        bit          known;
        idx        = int'(addr) % 4096;
        expq       = mem_model[idx];
        known      = mem_valid[idx];
        dm_address = addr;
        dm_data    = data;
        dm_wren    = wren;
        tick();
        if (wren && !reset) begin
            mem_model[idx] = data;
            mem_valid[idx] = 1'b1;
        end
        dm_wren = 1'b0;
        if (known) checkOutput("mem_read", dm_q, expq);
    endtask

    initial begin
        int r, f, fw;
        logic [15:0] ra, rb;
        logic [3:0]  rop;

        reset      = 1'b1;
        cnt_hold   = 1'b1;
        s_cnt_hold = 1'b1;
        dm_wren    = 1'b0;
        dm_address = 16'h0000;
        dm_data    = 16'h0000;
        exp_cnt    = 0;
        exp_cnt_s  = 0;
        for (int i = 0; i < 4096; i++) begin
            mem_model[i] = 16'h0000;
            mem_valid[i] = 1'b0;
        end
        applyStimulus(4'd0, 16'h0000, 16'h0000);
        #2;
        checkOutput("rst_cnt", cnt_out, 0);
        checkOutput("rst_dmq", dm_q, 0);
        checkOutput("rst_cnt_small", s_cnt_out, 0);

        aluDirected("add_ovf",  4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b1);
        aluDirected("add_carry",4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1'b1);
        aluDirected("sub_eq",   4'd1,  16'h0005, 16'h0005, 16'h0000, 4'b0100, 1'b1);
        aluDirected("cmp_eq",   4'd5,  16'h0005, 16'h0005, 16'h0000, 4'b0100, 1'b1);
        aluDirected("sub_borrow",4'd1, 16'h0003, 16'h0005, 16'hFFFE, 4'b1010, 1'b1);
        aluDirected("sub_ovf",  4'd1,  16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1'b1);
        aluDirected("sra3",     4'd11, 16'h8001, 16'h0003, 16'hF000, 4'b1000, 1'b1);
        aluDirected("srl1",     4'd10, 16'h8001, 16'h0001, 16'h4000, 4'b0010, 1'b1);
        aluDirected("sll1",     4'd8,  16'h8001, 16'h0001, 16'h0002, 4'b0010, 1'b1);
        aluDirected("slr1",     4'd9,  16'h8001, 16'h0001, 16'h0003, 4'b0010, 1'b1);
        aluDirected("sll0",     4'd8,  16'h8001, 16'h0010, 16'h8001, 4'b1000, 1'b1);
        aluDirected("slr0",     4'd9,  16'h8001, 16'h0000, 16'h8001, 4'b1000, 1'b1);
        aluDirected("srl0",     4'd10, 16'h8001, 16'h0000, 16'h8001, 4'b1000, 1'b1);
        aluDirected("sra0",     4'd11, 16'h8001, 16'h0000, 16'h8001, 4'b1000, 1'b1);
        aluDirected("in",       4'd12, 16'h5555, 16'h000A, 16'h000A, 4'b0000, 1'b0);
        aluDirected("out",      4'd13, 16'h1234, 16'h9999, 16'h1234, 4'b0000, 1'b0);
        aluDirected("halt",     4'd15, 16'h1234, 16'h9999, 16'h0000, 4'b0100, 1'b0);

        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 16'($urandom_range(0, 65535));
            rb  = 16'($urandom_range(0, 65535));
            if (i % 4 == 0) begin
                case ($urandom_range(0, 3))
                    0: ra = 16'h7FFF;
                    1: ra = 16'h8000;
                    2: ra = 16'hFFFF;
                    default: ra = 16'h0000;
                endcase
            end
            applyStimulus(rop, ra, rb);
            alu_model(int'(rop), int'(ra), int'(rb), r, f, fw);
            checkOutput("rnd_out", alu_out, r);
            checkOutput("rnd_flags", flag_out, f);
            checkOutput("rnd_fw", flag_write, fw);
        end

        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
        checkOutput("cnt_held_after_rst", cnt_out, exp_cnt);

        cnt_hold = 1'b0;
        repeat (5) tick();
        checkOutput("cnt_five", cnt_out, 5);
        cnt_hold = 1'b1;
        repeat (3) tick();
        checkOutput("cnt_hold", cnt_out, 5);
        checkOutput("cnt_model", cnt_out, exp_cnt);

        memStep(16'd5, 16'h1234, 1'b1);
        memStep(16'd5, 16'h0000, 1'b0);
        checkOutput("mem_wr_rd", dm_q, 16'h1234);
        memStep(16'd5, 16'hBEEF, 1'b1);
        checkOutput("mem_rdw_old", dm_q, 16'h1234);
        memStep(16'd5, 16'h0000, 1'b0);
        checkOutput("mem_rdw_new", dm_q, 16'hBEEF);
        memStep(16'd5 + 16'd4096, 16'h0000, 1'b0);
        checkOutput("mem_alias", dm_q, 16'hBEEF);
        memStep(16'd6, 16'h1111, 1'b1);

        for (int i = 0; i < 150; i++) begin
            cnt_hold = $urandom_range(0, 1) == 1;
            memStep(16'(($urandom_range(0, 15) << 12) | $urandom_range(0, 15)),
                    16'($urandom_range(0, 65535)), $urandom_range(0, 1) == 1);
            checkOutput("cnt_rnd", cnt_out, exp_cnt);
        end
        memStep(16'd5, 16'hBEEF, 1'b1);
        memStep(16'd6, 16'h1111, 1'b1);

        cnt_hold = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_cnt", cnt_out, 0);
        checkOutput("async_rst_dmq", dm_q, 0);
        dm_address = 16'd6;
        dm_data    = 16'h5555;
        dm_wren    = 1'b1;
        tick();
        dm_wren = 1'b0;
        reset   = 1'b0;
        memStep(16'd6, 16'h0000, 1'b0);
        checkOutput("wr_in_rst_ignored", dm_q, 16'h1111);
        memStep(16'd5, 16'h0000, 1'b0);
        checkOutput("mem_kept_over_rst", dm_q, 16'hBEEF);

        s_cnt_hold = 1'b0;
        repeat (15) tick();
        checkOutput("small_cnt_max", s_cnt_out, 15);
        tick();
        checkOutput("small_cnt_wrap", s_cnt_out, 0);
        checkOutput("small_cnt_model", s_cnt_out, exp_cnt_s);
        checkOutput("cnt_final", cnt_out, exp_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simple_exec_unit.md
Name: simple_exec_unit

Overview:
Execution-side datapath block for the 16-bit SIMPLE processor. It combines three parts:
- a combinational 16-bit ALU with S/Z/C/V flag generation and a flag-write qualifier;
- a 32-bit free-running cycle counter with a hold input;
- a synchronous single-port word-addressed data memory.

The phase controller drives it, supplying operands, opcode, memory address/data and the run/hold control.

Parameters:
DM_ADDR_WIDTH, 12, number of implemented data-memory address bits (depth = 2**DM_ADDR_WIDTH words of 16 bits)
CNT_WIDTH, 32, cycle counter width

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears counter and dm_q (not memory contents)
alu_op  input  4  ALU operation select (S_ALU encoding below)
alu_a  input  16  operand A (destination register value / PC)
alu_b  input  16  operand B (source register / sign-extended immediate / input port)
alu_out  output  16  combinational ALU result
flag_out  output  4  {S,Z,C,V} for current operation
flag_write  output  1  high when current op must update processor flags
cnt_hold  input  1  1 = counter holds value, 0 = counter increments
cnt_out  output  CNT_WIDTH  cycle counter value
dm_address  input  16  word address; low DM_ADDR_WIDTH bits used
dm_data  input  16  write data
dm_wren  input  1  write enable
dm_q  output  16  registered read data

Behaviour:
ALU (purely combinational, no clock dependence). Result R:
- 0 ADD: R=A+B. C=carry out of bit 15; V=signed overflow.
- 1 SUB: R=A-B. C=borrow (1 when A<B unsigned); V=signed overflow of A-B.
- 5 CMP: identical to SUB, including R.
- 2 AND, 3 OR, 4 XOR: bitwise. C=0, V=0.
- 6 MOV: R=B. C=0, V=0.
- 7 MUL: R=low 16 bits of unsigned A*B. C=0, V=0.
- Shifts (8–11) use amount n=B[3:0]. When n=0: R=A and C=0.
  - 8 SLL: R=A<<n. C=last bit shifted out (A[16-n]).
  - 9 SLR: rotate left by n. C=R[0].
  - 10 SRL: logical right. C=A[n-1].
  - 11 SRA: arithmetic right, sign-filled. C=A[n-1].
  - V=0 for all shifts.
- 12 IN: R=B, no flag write.
- 13 OUT: R=A, no flag write.
- 14 (unused) and 15 HALT: R=0, no flag write.

Flags:
- For every op: S=R[15], Z=(R==0).
- flag_write=1 for ops 0–11; 0 for ops 12–15.
- flag_out is always driven, even when flag_write=0.

Counter:
- Async reset to 0.
- On each rising clock edge with cnt_hold=0: increment by 1, wrapping from all-ones to 0.
- With cnt_hold=1: holds value.
- reset has priority over everything.

Data memory:
- Index = dm_address[DM_ADDR_WIDTH-1:0]. Upper address bits are ignored, so addresses alias and wrap.
- Write: on a rising edge with dm_wren=1, mem[index]<=dm_data.
- Read: dm_q<=mem[index] every rising edge, giving 1-cycle read latency.
- Same-address read during write returns the OLD contents; the new data is visible on the next cycle.
- reset clears dm_q to 0 asynchronously but does not alter array contents. Array initial contents are 0 at configuration.
- A write occurring while reset is asserted is ignored.

Test Plan:
- ADD A=0x7FFF,B=0x0001 -> alu_out=0x8000, flags S=1 Z=0 C=0 V=1, flag_write=1; ADD 0xFFFF+0x0001 -> 0x0000, S=0 Z=1 C=1 V=0.
- SUB/CMP A=0x0005,B=0x0005 -> 0x0000, Z=1 C=0 V=0; SUB 0x0003-0x0005 -> 0xFFFE, S=1 C=1; SUB 0x8000-0x0001 -> 0x7FFF, V=1.
- Shifts on A=0x8001:
  - SRA n=3 -> 0xF000, C=0.
  - SRL n=1 -> 0x4000, C=1.
  - SLL n=1 -> 0x0002, C=1.
  - SLR n=1 -> 0x0003, C=1.
  - Any op with n=0 -> 0x8001, C=0.
- IN B=0x000A -> 0x000A, flag_write=0; OUT A=0x1234 -> 0x1234, flag_write=0; HALT -> flag_write=0.
- Counter:
  - reset, then cnt_hold=0 for 5 clocks -> cnt_out=5.
  - cnt_hold=1 for 3 clocks -> stays 5.
  - Assert reset mid-cycle -> 0 immediately, without waiting for a clock edge.
  - Preloaded near 0xFFFFFFFF -> wraps to 0.
- Memory:
  - write 0x1234 to address 5; next-cycle read of 5 -> dm_q=0x1234.
  - Write 0xBEEF to address 5 while reading 5 -> dm_q=0x1234 that cycle, 0xBEEF the next.
  - Read address 5+2**DM_ADDR_WIDTH -> 0xBEEF (alias).
  - reset -> dm_q=0 and contents preserved.
